// File: rtl/dram_arbiter_if.sv
// Bundle of the two core request/response ports and the DRAM pin group.
// The arbiter uses the slave view; the cores plus DRAM side use the master view.
interface dram_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              c0_req_valid;
  logic              c0_req_ready;
  logic              c0_req_we;
  logic [ADDR_W-1:0] c0_req_addr;
  logic [DATA_W-1:0] c0_req_wdata;
  logic              c0_resp_valid;
  logic [DATA_W-1:0] c0_resp_rdata;

  logic              c1_req_valid;
  logic              c1_req_ready;
  logic              c1_req_we;
  logic [ADDR_W-1:0] c1_req_addr;
  logic [DATA_W-1:0] c1_req_wdata;
  logic              c1_resp_valid;
  logic [DATA_W-1:0] c1_resp_rdata;

  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  c0_req_valid, c0_req_we, c0_req_addr, c0_req_wdata,
    output c0_req_ready, c0_resp_valid, c0_resp_rdata,
    input  c1_req_valid, c1_req_we, c1_req_addr, c1_req_wdata,
    output c1_req_ready, c1_resp_valid, c1_resp_rdata,
    output mem_write_en, mem_addr, mem_data_in,
    input  mem_data_out
  );

  modport master (
    output c0_req_valid, c0_req_we, c0_req_addr, c0_req_wdata,
    input  c0_req_ready, c0_resp_valid, c0_resp_rdata,
    output c1_req_valid, c1_req_we, c1_req_addr, c1_req_wdata,
    input  c1_req_ready, c1_resp_valid, c1_resp_rdata,
    input  mem_write_en, mem_addr, mem_data_in,
    output mem_data_out
  );
endinterface

// File: rtl/dram_arbiter.sv
// Two-core round-robin initiator for a single-port DRAM with one-cycle
// synchronous read latency. One request in flight at a time.
module dram_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input logic           clk,
  input logic           rst,
  dram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, READ_WAIT} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;     // core granted on the most recent accept
  logic              owner_q, owner_d;   // core owning the request in flight
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              rv0_q, rv0_d;
  logic              rv1_q, rv1_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;

  logic sel;
  logic any_valid;
  logic accept;

  // Round-robin selection: a tie goes to the core not granted last time.
  always_comb begin
    any_valid = bus.c0_req_valid | bus.c1_req_valid;
    if (bus.c0_req_valid && bus.c1_req_valid) sel = ~last_q;
    else                                      sel = bus.c1_req_valid;
    accept = (state_q == IDLE) && any_valid;
  end

  assign bus.c0_req_ready  = accept && !sel;
  assign bus.c1_req_ready  = accept &&  sel;
  assign bus.mem_write_en  = we_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_data_in   = din_q;
  assign bus.c0_resp_valid = rv0_q;
  assign bus.c1_resp_valid = rv1_q;
  assign bus.c0_resp_rdata = rd0_q;
  assign bus.c1_resp_rdata = rd1_q;

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACCESS;
          owner_d = sel;
          last_d  = sel;
          we_d    = sel ? bus.c1_req_we    : bus.c0_req_we;
          addr_d  = sel ? bus.c1_req_addr  : bus.c0_req_addr;
          din_d   = sel ? bus.c1_req_wdata : bus.c0_req_wdata;
        end
      end
      ACCESS: begin
        we_d = 1'b0;
        if (we_q) begin
          state_d = IDLE;
          if (owner_q) rv1_d = 1'b1;
          else         rv0_d = 1'b1;
        end else begin
          state_d = READ_WAIT;
        end
      end
      READ_WAIT: begin
        state_d = IDLE;
        if (owner_q) begin
          rv1_d = 1'b1;
          rd1_d = bus.mem_data_out;
        end else begin
          rv0_d = 1'b1;
          rd0_d = bus.mem_data_out;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; async reset drops write_en immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: DRAM model, transaction-level reference model with a
// per-cycle compare process, and directed scenarios with literal expectations.
module tb_dram_arbiter;

  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  dram_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // DRAM: synchronous write, registered read data.
  logic [15:0] ram     [0:65535];
  logic [15:0] ref_mem [0:65535];
  always @(posedge clk) begin
    if (bus.mem_write_en) ram[bus.mem_addr] <= bus.mem_data_in;
    bus.mem_data_out <= ram[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction timeline) ----------------
  int          cyc     = 0;
  int          free_at = 0;
  int          last_g  = 1;
  logic [15:0] m_addr = '0, m_din = '0, m_rd0 = '0, m_rd1 = '0;
  bit          e_wen [MAXC];
  bit          e_rv0 [MAXC];
  bit          e_rv1 [MAXC];
  bit          e_set [MAXC];
  bit          e_rds [MAXC];
  bit          e_rdc [MAXC];
  logic [15:0] e_addr [MAXC];
  logic [15:0] e_din  [MAXC];
  logic [15:0] e_rdv  [MAXC];

  int grant_core[$];
  int grant_cyc[$];
  int wen_cnt = 0;

  task automatic model_reset();
    for (int i = cyc; i < MAXC; i++) begin
      e_wen[i] = 0; e_rv0[i] = 0; e_rv1[i] = 0; e_set[i] = 0; e_rds[i] = 0;
    end
    m_addr = '0; m_din = '0; m_rd0 = '0; m_rd1 = '0;
    free_at = 0;
    last_g  = 1;
  endtask

  // A request accepted at the end of cycle c occupies the DRAM in cycle c+1;
  // writes answer in c+2, reads in c+3 with the data as of that moment.
  task automatic model_accept(input int core, input logic we, input logic [15:0] a, input logic [15:0] d);
    if (cyc + 3 < MAXC) begin
      e_set[cyc+1]  = 1;
      e_addr[cyc+1] = a;
      e_din[cyc+1]  = d;
      e_wen[cyc+1]  = we;
      if (we) begin
        if (core == 0) e_rv0[cyc+2] = 1; else e_rv1[cyc+2] = 1;
        free_at = cyc + 2;
      end else begin
        if (core == 0) e_rv0[cyc+3] = 1; else e_rv1[cyc+3] = 1;
        e_rds[cyc+3] = 1;
        e_rdc[cyc+3] = (core == 1);
        e_rdv[cyc+3] = ref_mem[a];
        free_at = cyc + 3;
      end
    end
    last_g = core;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    bit r0, r1;
    cyc++;
    if (rst) begin
      model_reset();
      chk("rst_wen",  bus.mem_write_en,  0);
      chk("rst_addr", bus.mem_addr,      0);
      chk("rst_din",  bus.mem_data_in,   0);
      chk("rst_rv0",  bus.c0_resp_valid, 0);
      chk("rst_rv1",  bus.c1_resp_valid, 0);
      chk("rst_rd0",  bus.c0_resp_rdata, 0);
      chk("rst_rd1",  bus.c1_resp_rdata, 0);
    end else begin
      if (e_set[cyc]) begin
        m_addr = e_addr[cyc];
        m_din  = e_din[cyc];
        if (e_wen[cyc]) ref_mem[m_addr] = m_din;
      end
      if (e_rds[cyc]) begin
        if (e_rdc[cyc]) m_rd1 = e_rdv[cyc]; else m_rd0 = e_rdv[cyc];
      end
      if (bus.mem_write_en === 1'b1) wen_cnt++;
      chk("wen",  bus.mem_write_en,  e_wen[cyc]);
      chk("addr", bus.mem_addr,      m_addr);
      chk("din",  bus.mem_data_in,   m_din);
      chk("rv0",  bus.c0_resp_valid, e_rv0[cyc]);
      chk("rv1",  bus.c1_resp_valid, e_rv1[cyc]);
      chk("rd0",  bus.c0_resp_rdata, m_rd0);
      chk("rd1",  bus.c1_resp_rdata, m_rd1);
      r0 = 0; r1 = 0;
      if (cyc >= free_at) begin
        if (bus.c0_req_valid && bus.c1_req_valid) begin
          if (last_g == 1) r0 = 1; else r1 = 1;
        end else if (bus.c0_req_valid) r0 = 1;
        else if (bus.c1_req_valid) r1 = 1;
      end
      chk("rdy0", bus.c0_req_ready, r0);
      chk("rdy1", bus.c1_req_ready, r1);
      if (bus.c0_req_valid && bus.c0_req_ready) begin
        grant_core.push_back(0); grant_cyc.push_back(cyc);
      end
      if (bus.c1_req_valid && bus.c1_req_ready) begin
        grant_core.push_back(1); grant_cyc.push_back(cyc);
      end
      if (bus.c0_req_valid && r0)
        model_accept(0, bus.c0_req_we, bus.c0_req_addr, bus.c0_req_wdata);
      else if (bus.c1_req_valid && r1)
        model_accept(1, bus.c1_req_we, bus.c1_req_addr, bus.c1_req_wdata);
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic req(input int core, input logic we, input logic [15:0] a, input logic [15:0] d);
    bit done = 0;
    if (core == 0) begin
      bus.c0_req_valid = 1; bus.c0_req_we = we; bus.c0_req_addr = a; bus.c0_req_wdata = d;
    end else begin
      bus.c1_req_valid = 1; bus.c1_req_we = we; bus.c1_req_addr = a; bus.c1_req_wdata = d;
    end
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if ((core == 0) ? bus.c0_req_ready : bus.c1_req_ready) done = 1;
      @(posedge clk); #1;
    end
    if (core == 0) bus.c0_req_valid = 0; else bus.c1_req_valid = 0;
    if (!done) chk($sformatf("accept_timeout_c%0d", core), 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.c0_req_valid = 0; bus.c1_req_valid = 0;
    #1 rst = 1;
    idle(2);
    rst = 0;
    grant_core.delete(); grant_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    ram[10] = 16'd85;      ref_mem[10] = 16'd85;
    ram[15] = 16'd95;      ref_mem[15] = 16'd95;
    ram[75] = 16'd91;      ref_mem[75] = 16'd91;
    ram[85] = 16'd101;     ref_mem[85] = 16'd101;
    ram[16'h20] = 16'h0BAD; ref_mem[16'h20] = 16'h0BAD;
    bus.c0_req_valid = 0; bus.c0_req_we = 0; bus.c0_req_addr = '0; bus.c0_req_wdata = '0;
    bus.c1_req_valid = 0; bus.c1_req_we = 0; bus.c1_req_addr = '0; bus.c1_req_wdata = '0;
    #1;
    chk("por_wen",  bus.mem_write_en, 0);
    chk("por_addr", bus.mem_addr,     0);
    idle(3);
    rst = 0;

    // Core 0 write then read back.
    wen_cnt = 0;
    req(0, 1, 16'h0005, 16'h1234);
    idle(1);
    chk("lit_wr_rv0", bus.c0_resp_valid, 1);
    req(0, 0, 16'h0005, 16'h0000);
    idle(2);
    chk("lit_rd_rv0", bus.c0_resp_valid, 1);
    chk("lit_rd_rd0", bus.c0_resp_rdata, 16'h1234);
    chk("lit_wen_cycles", wen_cnt, 1);

    // Core 1 read of a preloaded word.
    do_reset();
    req(1, 0, 16'd10, 16'h0000);
    idle(2);
    chk("lit_c1_rv1", bus.c1_resp_valid, 1);
    chk("lit_c1_rd1", bus.c1_resp_rdata, 16'd85);
    chk("lit_c1_rv0", bus.c0_resp_valid, 0);

    // Simultaneous reads after reset: core 0 first, core 1 three cycles later.
    do_reset();
    fork
      req(0, 0, 16'd15, 16'h0000);
      req(1, 0, 16'd75, 16'h0000);
    join
    idle(3);
    chk("lit_tie_rd0", bus.c0_resp_rdata, 16'd95);
    chk("lit_tie_rd1", bus.c1_resp_rdata, 16'd91);
    chk("lit_tie_n", grant_core.size(), 2);
    if (grant_core.size() == 2) begin
      chk("lit_tie_first", grant_core[0], 0);
      chk("lit_tie_gap", grant_cyc[1] - grant_cyc[0], 3);
    end

    // Continuous writes from both cores alternate grants.
    do_reset();
    fork
      for (int i = 0; i < 4; i++) req(0, 1, 16'h0040 + 16'(i), 16'hA000 + 16'(i));
      for (int j = 0; j < 4; j++) req(1, 1, 16'h0050 + 16'(j), 16'hB000 + 16'(j));
    join
    idle(3);
    chk("lit_alt_n", grant_core.size(), 8);
    for (int i = 0; i < grant_core.size() && i < 8; i++)
      chk($sformatf("lit_alt_g%0d", i), grant_core[i], i % 2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lit_ram_c0_%0d", i), ram[16'h0040 + i], 16'hA000 + i);
      chk($sformatf("lit_ram_c1_%0d", i), ram[16'h0050 + i], 16'hB000 + i);
    end

    // Reset during the ACCESS cycle of a write aborts it.
    req(0, 1, 16'h0020, 16'hBEEF);
    #1 rst = 1;
    #1;
    chk("lit_abort_wen", bus.mem_write_en, 0);
    chk("lit_abort_rv0", bus.c0_resp_valid, 0);
    idle(1);
    rst = 0;
    idle(3);
    req(0, 0, 16'h0020, 16'h0000);
    idle(2);
    chk("lit_abort_rd0", bus.c0_resp_rdata, 16'h0BAD);

    // Core 1 read data holds through a following core 0 write.
    fork
      req(1, 0, 16'd85, 16'h0000);
      begin idle(1); req(0, 1, 16'h0030, 16'h7777); end
    join
    idle(2);
    chk("lit_hold_rd1", bus.c1_resp_rdata, 16'd101);
    chk("lit_hold_ram", ram[16'h0030], 16'h7777);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
